// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types for the branch predictor: counter states, BTB entry, default depth
package bp_pkg;

  localparam int DEFAULT_ENTRIES = 64;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_state_e;

  // Tag is held zero-extended to the widest case so one struct fits every depth.
  typedef struct packed {
    logic        valid;
    logic        is_jump;
    logic [29:0] tag;
    logic [29:0] target;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating counter next-state logic
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_state_e state_i,
  input  logic       taken_i,
  output ctr_state_e state_o
);

  always_comb begin
    state_o = state_i;
    case (state_i)
      SNT:     state_o = taken_i ? WNT : SNT;
      WNT:     state_o = taken_i ? WT  : SNT;
      WT:      state_o = taken_i ? ST  : WNT;
      ST:      state_o = taken_i ? ST  : WT;
      default: state_o = WNT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal PHT + direct-mapped BTB predictor with Execute-stage resolution
// Optional gshare indexing of the PHT when BP_GSHARE_EN is defined.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = DEFAULT_ENTRIES
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [31:0]                pcF,
  output logic                       predTakenF,
  output logic [31:0]                predTargetF,
  output logic [$clog2(ENTRIES)-1:0] idxF,
  input  logic                       branchE,
  input  logic                       jumpE,
  input  logic                       takenE,
  input  logic [31:0]                pcE,
  input  logic [31:0]                targetE,
  input  logic                       predTakenE,
  input  logic [31:0]                predTargetE,
  input  logic [$clog2(ENTRIES)-1:0] idxE,
  output logic                       wrongBranchE,
  output logic [31:0]                redirectPcE
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  ctr_state_e        pht_q   [ENTRIES];
  ctr_state_e        pht_d   [ENTRIES];
  logic              valid_q [ENTRIES];
  logic              valid_d [ENTRIES];
  logic              jump_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [29:0]       target_q[ENTRIES];

  logic [IDX_W-1:0]  btb_idx_f;
  logic [IDX_W-1:0]  btb_idx_e;
  btb_entry_t        rd_entry;
  btb_entry_t        wr_entry;
  logic              hit_f;
  ctr_state_e        ctr_f;
  ctr_state_e        ctr_next_e;
  logic              btb_wr;
  logic              btb_inv;
  logic              resolved_e;

  assign btb_idx_f  = pcF[IDX_W+1:2];
  assign btb_idx_e  = pcE[IDX_W+1:2];
  assign resolved_e = branchE | jumpE;
  assign btb_wr     = resolved_e && takenE;
  assign btb_inv    = predTakenE && !branchE && !jumpE;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (branchE) ghr_d = {ghr_q[IDX_W-2:0], takenE};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  assign idxF = btb_idx_f ^ ghr_q;
`else
  assign idxF = btb_idx_f;
`endif

  // Fetch lookup reads only _q state, so a same-cycle E write is seen one cycle later.
  always_comb begin
    rd_entry.valid   = valid_q[btb_idx_f];
    rd_entry.is_jump = jump_q[btb_idx_f];
    rd_entry.tag     = 30'(tag_q[btb_idx_f]);
    rd_entry.target  = target_q[btb_idx_f];
  end

  assign ctr_f       = pht_q[idxF];
  assign hit_f       = rd_entry.valid && (rd_entry.tag[TAG_W-1:0] == pcF[31:IDX_W+2]);
  assign predTakenF  = hit_f && (rd_entry.is_jump || ctr_f == WT || ctr_f == ST);
  assign predTargetF = predTakenF ? {rd_entry.target, 2'b00} : pcF + 32'd4;

  assign wrongBranchE = (resolved_e && (takenE != predTakenE ||
                                        (takenE && targetE != predTargetE))) || btb_inv;
  assign redirectPcE  = (resolved_e && takenE) ? targetE : pcE + 32'd4;

  sat_counter2 u_sat_counter2 (
    .state_i (pht_q[idxE]),
    .taken_i (takenE),
    .state_o (ctr_next_e)
  );

  always_comb begin
    pht_d = pht_q;
    if (branchE) pht_d[idxE] = ctr_next_e;
  end

  always_comb begin
    valid_d = valid_q;
    if (btb_wr)       valid_d[btb_idx_e] = 1'b1;
    else if (btb_inv) valid_d[btb_idx_e] = 1'b0;
  end

  always_comb begin
    wr_entry.valid   = 1'b1;
    wr_entry.is_jump = jumpE;
    wr_entry.tag     = 30'(pcE[31:IDX_W+2]);
    wr_entry.target  = targetE[31:2];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i]   <= WNT;
        valid_q[i] <= 1'b0;
      end
    end else begin
      pht_q   <= pht_d;
      valid_q <= valid_d;
    end
  end

  // Tag/target/kind payload is qualified by valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      jump_q[btb_idx_e]   <= wr_entry.is_jump;
      tag_q[btb_idx_e]    <= wr_entry.tag[TAG_W-1:0];
      target_q[btb_idx_e] <= wr_entry.target;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{wr_entry.valid, wr_entry.tag, rd_entry.tag, targetE[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor (gshare off)
module tb_branch_predictor;

  logic        clk;
  logic        rstN;
  logic [31:0] pcF;
  logic        predTakenF;
  logic [31:0] predTargetF;
  logic [5:0]  idxF;
  logic        branchE;
  logic        jumpE;
  logic        takenE;
  logic [31:0] pcE;
  logic [31:0] targetE;
  logic        predTakenE;
  logic [31:0] predTargetE;
  logic [5:0]  idxE;
  logic        wrongBranchE;
  logic [31:0] redirectPcE;

  int n_checks = 0;
  int n_pass   = 0;

  branch_predictor #(.ENTRIES(64)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .pcF          (pcF),
    .predTakenF   (predTakenF),
    .predTargetF  (predTargetF),
    .idxF         (idxF),
    .branchE      (branchE),
    .jumpE        (jumpE),
    .takenE       (takenE),
    .pcE          (pcE),
    .targetE      (targetE),
    .predTakenE   (predTakenE),
    .predTargetE  (predTargetE),
    .idxE         (idxE),
    .wrongBranchE (wrongBranchE),
    .redirectPcE  (redirectPcE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic drive_e(input logic br, input logic jp, input logic tk, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    branchE     = br;
    jumpE       = jp;
    takenE      = tk;
    pcE         = pc;
    targetE     = tgt;
    predTakenE  = ptk;
    predTargetE = ptgt;
    idxE        = pc[7:2];
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_tk,
                      input logic [31:0] exp_tgt);
    pcF = pc;
    #1;
    check({tag, "_tk"}, {31'b0, predTakenF}, {31'b0, exp_tk});
    check({tag, "_tgt"}, predTargetF, exp_tgt);
  endtask

  task automatic check_e(input string tag, input logic exp_wrong, input logic [31:0] exp_redir);
    check({tag, "_wrong"}, {31'b0, wrongBranchE}, {31'b0, exp_wrong});
    if (exp_wrong) check({tag, "_redir"}, redirectPcE, exp_redir);
  endtask

  initial begin
    rstN = 1'b0;
    pcF  = 32'h100;
    drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    look("reset", 32'h100, 1'b0, 32'h104);
    check("reset_idx", {26'b0, idxF}, 32'h0);
    pcF = 32'h104;
    #1;
    check("idx_104", {26'b0, idxF}, 32'h1);
    rstN = 1'b1;
    tick();

    // Training: branch 0x200 -> 0x180, counter starts weakly not-taken.
    look("train_pre", 32'h200, 1'b0, 32'h204);
    drive_e(1'b1, 1'b0, 1'b1, 32'h200, 32'h180, 1'b0, 32'h204);
    check_e("train1", 1'b1, 32'h180);
    tick();
    look("train_mid", 32'h200, 1'b1, 32'h180);
    drive_e(1'b1, 1'b0, 1'b1, 32'h200, 32'h180, 1'b1, 32'h180);
    check_e("train2", 1'b0, 32'h0);
    tick();
    look("train_post", 32'h200, 1'b1, 32'h180);

    // Saturation: two more taken (counter held at 3), then not-taken twice.
    for (int i = 0; i < 2; i++) begin
      drive_e(1'b1, 1'b0, 1'b1, 32'h200, 32'h180, 1'b1, 32'h180);
      tick();
    end
    drive_e(1'b1, 1'b0, 1'b0, 32'h200, 32'h180, 1'b1, 32'h180);
    check_e("sat_nt1", 1'b1, 32'h204);
    tick();
    look("sat_after_nt1", 32'h200, 1'b1, 32'h180);
    drive_e(1'b1, 1'b0, 1'b0, 32'h200, 32'h180, 1'b1, 32'h180);
    tick();
    look("sat_after_nt2", 32'h200, 1'b0, 32'h204);

    // Aliasing: JAL at 0x300 trains the shared entry, then a non-branch predicted taken clears it.
    drive_e(1'b0, 1'b1, 1'b1, 32'h300, 32'h380, 1'b0, 32'h304);
    check_e("jal300", 1'b1, 32'h380);
    tick();
    look("jal300_hit", 32'h300, 1'b1, 32'h380);
    look("tag_miss", 32'h200, 1'b0, 32'h204);
    drive_e(1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 32'h380);
    check_e("alias", 1'b1, 32'h304);
    tick();
    look("alias_inv", 32'h300, 1'b0, 32'h304);

    // Collision: F and E hit the same entry in the same cycle; counter is 1 here.
    pcF = 32'h400;
    drive_e(1'b1, 1'b0, 1'b1, 32'h400, 32'h480, 1'b0, 32'h404);
    look("coll_same", 32'h400, 1'b0, 32'h404);
    tick();
    look("coll_next", 32'h400, 1'b1, 32'h480);

    // Target mismatch on a JAL.
    drive_e(1'b0, 1'b1, 1'b1, 32'h500, 32'h600, 1'b0, 32'h504);
    tick();
    look("jal500", 32'h500, 1'b1, 32'h600);
    drive_e(1'b0, 1'b1, 1'b1, 32'h500, 32'h640, 1'b1, 32'h600);
    check_e("tgt_mis", 1'b1, 32'h640);
    tick();
    look("tgt_upd", 32'h500, 1'b1, 32'h640);
    drive_e(1'b0, 1'b1, 1'b1, 32'h500, 32'h640, 1'b1, 32'h640);
    check_e("tgt_ok", 1'b0, 32'h0);

    // Mid-operation reset drops the pending update and clears the BTB immediately.
    #1;
    rstN = 1'b0;
    #1;
    look("rst_mid", 32'h500, 1'b0, 32'h504);
    tick();
    rstN = 1'b1;
    tick();
    look("rst_after", 32'h500, 1'b0, 32'h504);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
